// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: control bundle field map,
// ID/EX hazard FSM states and the hardwired-zero register address.
package mips_pipe_pkg;

    localparam int CTRL_W = 16;

    // Bit positions inside the packed control bundle; multi-bit fields give their LSB
    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMREAD    = 1;
    localparam int CTRL_MEMWRITE   = 2;
    localparam int CTRL_MEMTOREG   = 3;
    localparam int CTRL_MEMTOREG_W = 2;
    localparam int CTRL_ALUSRCA    = 5;
    localparam int CTRL_ALUSRCB    = 6;
    localparam int CTRL_ALUOP      = 7;
    localparam int CTRL_ALUOP_W    = 4;
    localparam int CTRL_REGDST     = 11;
    localparam int CTRL_REGDST_W   = 2;
    localparam int CTRL_BRANCH     = 13;
    localparam int CTRL_SPARE      = 14;
    localparam int CTRL_SPARE_W    = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } idex_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction being decoded in ID.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic       exValid,
    input  logic       exMemRead,
    input  logic [4:0] exRtAddr,
    input  logic       idValid,
    input  logic [4:0] idRsAddr,
    input  logic [4:0] idRtAddr,
    input  logic       idUsesRs,
    input  logic       idUsesRt,
    output logic       hazard
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = idUsesRs && (exRtAddr == idRsAddr);
    assign rtMatch = idUsesRt && (exRtAddr == idRtAddr);

    // A load into $0 never produces a value worth waiting for
    assign hazard = idValid && exValid && exMemRead && (exRtAddr != REG_ZERO)
                    && (rsMatch || rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM: holds PC and IF/ID while
// injecting bubbles into EX, and squashes ID when EX redirects the fetch.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CTRL_W           = mips_pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc_plus4,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm_ext,
    input  logic [4:0]        id_rs_addr,
    input  logic [4:0]        id_rt_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [4:0]        id_shamt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [31:0]       ex_pc_plus4,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm_ext,
    output logic [4:0]        ex_rs_addr,
    output logic [4:0]        ex_rt_addr,
    output logic [4:0]        ex_rd_addr,
    output logic [4:0]        ex_shamt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall,
    output logic [15:0]       bubble_count
);

    idex_state_t state;
    idex_state_t nextState;
    logic [1:0]  cnt;
    logic [1:0]  nextCnt;
    logic        hazard;
    logic        loadBubble;
    logic        countBubble;
    logic        stallRaw;

    load_use_detect u_detect (
        .exValid   (ex_valid),
        .exMemRead (ex_ctrl[CTRL_MEMREAD]),
        .exRtAddr  (ex_rt_addr),
        .idValid   (id_valid),
        .idRsAddr  (id_rs_addr),
        .idRtAddr  (id_rt_addr),
        .idUsesRs  (id_uses_rs),
        .idUsesRt  (id_uses_rt),
        .hazard    (hazard)
    );

    // Flush wins over everything: the squashed slot becomes a bubble but is
    // not counted, and any pending stall window is abandoned.
    always_comb begin
        nextState   = state;
        nextCnt     = cnt;
        stallRaw    = 1'b0;
        loadBubble  = 1'b0;
        countBubble = 1'b0;
        if (ex_flush) begin
            loadBubble = 1'b1;
            nextState  = RUN;
            nextCnt    = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        stallRaw    = 1'b1;
                        loadBubble  = 1'b1;
                        countBubble = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            nextState = STALL;
                            nextCnt   = 2'(LOAD_USE_BUBBLES - 1);
                        end
                    end
                end
                STALL: begin
                    stallRaw    = 1'b1;
                    loadBubble  = 1'b1;
                    countBubble = 1'b1;
                    nextCnt     = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState = RUN;
                    nextCnt   = 2'd0;
                end
            endcase
        end
    end

    // Reset may land mid-stall, so stall is masked while rst_n is low
    assign stall = rst_n && stallRaw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= 2'd0;
            bubble_count <= 16'd0;
            ex_valid     <= 1'b0;
            ex_pc_plus4  <= 32'd0;
            ex_rs_data   <= 32'd0;
            ex_rt_data   <= 32'd0;
            ex_imm_ext   <= 32'd0;
            ex_rs_addr   <= 5'd0;
            ex_rt_addr   <= 5'd0;
            ex_rd_addr   <= 5'd0;
            ex_shamt     <= 5'd0;
            ex_ctrl      <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (countBubble && (bubble_count != 16'hFFFF)) begin
                bubble_count <= bubble_count + 16'd1;
            end
            if (loadBubble) begin
                ex_valid    <= 1'b0;
                ex_pc_plus4 <= 32'd0;
                ex_rs_data  <= 32'd0;
                ex_rt_data  <= 32'd0;
                ex_imm_ext  <= 32'd0;
                ex_rs_addr  <= 5'd0;
                ex_rt_addr  <= 5'd0;
                ex_rd_addr  <= 5'd0;
                ex_shamt    <= 5'd0;
                ex_ctrl     <= '0;
            end else begin
                ex_valid    <= id_valid;
                ex_pc_plus4 <= id_pc_plus4;
                ex_rs_data  <= id_rs_data;
                ex_rt_data  <= id_rt_data;
                ex_imm_ext  <= id_imm_ext;
                ex_rs_addr  <= id_rs_addr;
                ex_rt_addr  <= id_rt_addr;
                ex_rd_addr  <= id_rd_addr;
                ex_shamt    <= id_shamt;
                ex_ctrl     <= id_valid ? id_ctrl : '0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: one instance with a single load-use bubble,
// one with three, sharing the ID-side stimulus and selected via sel.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [15:0] ctrl;
        logic [31:0] rsData;
        logic [31:0] immExt;
    } exRec_t;

    localparam logic [15:0] LW_CTRL  = (16'd1 << CTRL_REGWRITE) | (16'd1 << CTRL_MEMREAD)
                                     | (16'd1 << CTRL_MEMTOREG) | (16'd1 << CTRL_ALUSRCB);
    localparam logic [15:0] ADD_CTRL = 16'h0421;
    localparam logic [15:0] SUB_CTRL = 16'h0C21;

    logic        clk = 1'b0;
    logic        rstA, rstB;
    logic        idValid;
    logic [31:0] idPc, idRsData, idRtData, idImm;
    logic [4:0]  idRs, idRt, idRd, idShamt;
    logic        idUsesRs, idUsesRt;
    logic [15:0] idCtrl;
    logic        exFlush;

    logic        aValid, bValid, aStall, bStall;
    logic [31:0] aPc, aRs, aRt, aImm, bPc, bRs, bRt, bImm;
    logic [4:0]  aRsA, aRtA, aRdA, aSh, bRsA, bRtA, bRdA, bSh;
    logic [15:0] aCtrl, bCtrl, aCount, bCount;

    logic         sel;
    exRec_t       obsEx;
    logic         obsStall;
    logic [15:0]  obsCount;
    logic [180:0] obsAll;

    exRec_t sbq[$];
    exRec_t expRec;
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.LOAD_USE_BUBBLES(1)) dutA (
        .clk(clk), .rst_n(rstA), .id_valid(idValid), .id_pc_plus4(idPc),
        .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm_ext(idImm),
        .id_rs_addr(idRs), .id_rt_addr(idRt), .id_rd_addr(idRd), .id_shamt(idShamt),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_ctrl(idCtrl), .ex_flush(exFlush),
        .ex_valid(aValid), .ex_pc_plus4(aPc), .ex_rs_data(aRs), .ex_rt_data(aRt),
        .ex_imm_ext(aImm), .ex_rs_addr(aRsA), .ex_rt_addr(aRtA), .ex_rd_addr(aRdA),
        .ex_shamt(aSh), .ex_ctrl(aCtrl), .stall(aStall), .bubble_count(aCount)
    );

    id_ex_stage #(.LOAD_USE_BUBBLES(3)) dutB (
        .clk(clk), .rst_n(rstB), .id_valid(idValid), .id_pc_plus4(idPc),
        .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm_ext(idImm),
        .id_rs_addr(idRs), .id_rt_addr(idRt), .id_rd_addr(idRd), .id_shamt(idShamt),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_ctrl(idCtrl), .ex_flush(exFlush),
        .ex_valid(bValid), .ex_pc_plus4(bPc), .ex_rs_data(bRs), .ex_rt_data(bRt),
        .ex_imm_ext(bImm), .ex_rs_addr(bRsA), .ex_rt_addr(bRtA), .ex_rd_addr(bRdA),
        .ex_shamt(bSh), .ex_ctrl(bCtrl), .stall(bStall), .bubble_count(bCount)
    );

    always_comb begin
        obsEx    = sel ? {bValid, bCtrl, bRs, bImm} : {aValid, aCtrl, aRs, aImm};
        obsStall = sel ? bStall : aStall;
        obsCount = sel ? bCount : aCount;
        obsAll   = sel ? {bValid, bPc, bRs, bRt, bImm, bRsA, bRtA, bRdA, bSh, bCtrl, bCount}
                       : {aValid, aPc, aRs, aRt, aImm, aRsA, aRtA, aRdA, aSh, aCtrl, aCount};
    end

    function automatic exRec_t mk(input logic v, input logic [15:0] c,
                                  input logic [31:0] r, input logic [31:0] i);
        mk = {v, c, r, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic ut, input logic [15:0] c,
                         input logic [31:0] rsData, input logic [31:0] imm);
        idValid  = v;
        idRs     = rs;
        idRt     = rt;
        idUsesRs = ur;
        idUsesRt = ut;
        idCtrl   = c;
        idRsData = rsData;
        idImm    = imm;
        idRtData = rsData ^ 32'h0F0F_0F0F;
        idPc     = 32'h0040_0000 + imm;
        idRd     = rs ^ rt;
        idShamt  = rt;
    endtask

    task automatic doReset(input logic s);
        exFlush = 1'b0;
        setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        if (s) rstB = 1'b0; else rstA = 1'b0;
        tick();
        if (s) rstB = 1'b1; else rstA = 1'b1;
        sbq.delete();
    endtask

    task automatic test_reset();
        exFlush = 1'b0;
        rstA = 1'b0;
        rstB = 1'b0;
        setId(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, LW_CTRL, 32'hDEAD_BEEF, 32'h4);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++;
            if (obsStall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_stall[%0d] got=%b want=0", s, obsStall);
            end
        end
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++;
            if (obsAll !== '0 || obsStall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_outputs[%0d] got=%h stall=%b want=0", s, obsAll, obsStall);
            end
        end
        rstA = 1'b1;
        rstB = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [31:0] rnd;
        sel = 1'b0;
        doReset(1'b0);
        rnd = $urandom;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    setId(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 16'h0421, 32'h1234_5678, 32'hFFFF_8000);
                    sbq.push_back(mk(1'b1, 16'h0421, 32'h1234_5678, 32'hFFFF_8000));
                end
                1: begin
                    setId(1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 16'h0421, 32'hCAFE_0001, 32'h0001_0000);
                    sbq.push_back(mk(1'b0, 16'h0, 32'hCAFE_0001, 32'h0001_0000));
                end
                default: begin
                    setId(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, SUB_CTRL, rnd, ~rnd);
                    sbq.push_back(mk(1'b1, SUB_CTRL, rnd, ~rnd));
                end
            endcase
            #1;
            total++;
            if (obsStall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL pass_stall[%0d] got=%b want=0", k, obsStall);
            end
            tick();
            expRec = sbq.pop_front();
            total++;
            if (obsEx !== expRec) begin
                bad++;
                $display("[TB] FAIL pass_ex[%0d] got=%h want=%h", k, obsEx, expRec);
            end
        end
    endtask

    task automatic test_load_use(input logic s, input int lub);
        logic expStall;
        sel = s;
        doReset(s);
        for (int k = 0; k <= lub + 1; k++) begin
            expStall = (k >= 1) && (k <= lub);
            if (k == 0) begin
                setId(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, LW_CTRL, 32'h0000_1000, 32'h4);
                sbq.push_back(mk(1'b1, LW_CTRL, 32'h0000_1000, 32'h4));
            end else begin
                setId(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, ADD_CTRL, 32'hA5A5_A5A5, 32'h0);
                sbq.push_back(expStall ? mk(1'b0, 16'h0, 32'h0, 32'h0)
                                       : mk(1'b1, ADD_CTRL, 32'hA5A5_A5A5, 32'h0));
            end
            #1;
            total++;
            if (obsStall !== expStall) begin
                bad++;
                $display("[TB] FAIL loaduse%0d_stall[%0d] got=%b want=%b", lub, k, obsStall, expStall);
            end
            tick();
            expRec = sbq.pop_front();
            total++;
            if (obsEx !== expRec) begin
                bad++;
                $display("[TB] FAIL loaduse%0d_ex[%0d] got=%h want=%h", lub, k, obsEx, expRec);
            end
        end
        total++;
        if (obsCount !== 16'(lub)) begin
            bad++;
            $display("[TB] FAIL loaduse%0d_count got=%0d want=%0d", lub, obsCount, lub);
        end
    endtask

    task automatic test_no_false_hazard();
        logic [4:0]  rsT[4]  = '{5'd1, 5'd0, 5'd1, 5'd3};
        logic [4:0]  rtT[4]  = '{5'd0, 5'd0, 5'd9, 5'd9};
        logic        urT[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic        utT[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] ctT[4]  = '{LW_CTRL, ADD_CTRL, LW_CTRL, ADD_CTRL};
        sel = 1'b0;
        doReset(1'b0);
        for (int k = 0; k < 4; k++) begin
            setId(1'b1, rsT[k], rtT[k], urT[k], utT[k], ctT[k], 32'h100 + k, 32'h10 * k);
            sbq.push_back(mk(1'b1, ctT[k], 32'h100 + k, 32'h10 * k));
            #1;
            total++;
            if (obsStall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL nofalse_stall[%0d] got=%b want=0", k, obsStall);
            end
            tick();
            expRec = sbq.pop_front();
            total++;
            if (obsEx !== expRec) begin
                bad++;
                $display("[TB] FAIL nofalse_ex[%0d] got=%h want=%h", k, obsEx, expRec);
            end
        end
        total++;
        if (obsCount !== 16'd0) begin
            bad++;
            $display("[TB] FAIL nofalse_count got=%0d want=0", obsCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rsT[5] = '{5'd1, 5'd8, 5'd8, 5'd9, 5'd9};
        logic [4:0]  rtT[5] = '{5'd8, 5'd9, 5'd9, 5'd10, 5'd10};
        logic        utT[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ctT[5] = '{LW_CTRL, LW_CTRL, LW_CTRL, ADD_CTRL, ADD_CTRL};
        logic        stT[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        sel = 1'b0;
        doReset(1'b0);
        for (int k = 0; k < 5; k++) begin
            setId(1'b1, rsT[k], rtT[k], 1'b1, utT[k], ctT[k], 32'h200 + k, 32'h8);
            sbq.push_back(stT[k] ? mk(1'b0, 16'h0, 32'h0, 32'h0)
                                 : mk(1'b1, ctT[k], 32'h200 + k, 32'h8));
            #1;
            total++;
            if (obsStall !== stT[k]) begin
                bad++;
                $display("[TB] FAIL b2b_stall[%0d] got=%b want=%b", k, obsStall, stT[k]);
            end
            tick();
            expRec = sbq.pop_front();
            total++;
            if (obsEx !== expRec) begin
                bad++;
                $display("[TB] FAIL b2b_ex[%0d] got=%h want=%h", k, obsEx, expRec);
            end
        end
        total++;
        if (obsCount !== 16'd2) begin
            bad++;
            $display("[TB] FAIL b2b_count got=%0d want=2", obsCount);
        end
    endtask

    task automatic test_flush();
        logic        flT[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        stT[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] cnT[4] = '{16'd0, 16'd1, 16'd1, 16'd1};
        // Flush in the second cycle of a three-bubble stall
        sel = 1'b1;
        doReset(1'b1);
        for (int k = 0; k < 4; k++) begin
            exFlush = flT[k];
            case (k)
                0: setId(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, LW_CTRL, 32'h300, 32'h4);
                3: setId(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, SUB_CTRL, 32'h0BAD_F00D, 32'h7);
                default: setId(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, ADD_CTRL, 32'h301, 32'h0);
            endcase
            if (k == 0)      sbq.push_back(mk(1'b1, LW_CTRL, 32'h300, 32'h4));
            else if (k == 3) sbq.push_back(mk(1'b1, SUB_CTRL, 32'h0BAD_F00D, 32'h7));
            else             sbq.push_back(mk(1'b0, 16'h0, 32'h0, 32'h0));
            #1;
            total++;
            if (obsStall !== stT[k]) begin
                bad++;
                $display("[TB] FAIL flush_stall[%0d] got=%b want=%b", k, obsStall, stT[k]);
            end
            tick();
            expRec = sbq.pop_front();
            total++;
            if (obsEx !== expRec || obsCount !== cnT[k]) begin
                bad++;
                $display("[TB] FAIL flush_ex[%0d] got=%h cnt=%0d want=%h cnt=%0d",
                         k, obsEx, obsCount, expRec, cnT[k]);
            end
        end
        // Hazard and flush in the same cycle on the single-bubble instance
        sel = 1'b0;
        doReset(1'b0);
        for (int k = 0; k < 3; k++) begin
            exFlush = (k == 1);
            if (k == 0) begin
                setId(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, LW_CTRL, 32'h400, 32'h4);
                sbq.push_back(mk(1'b1, LW_CTRL, 32'h400, 32'h4));
            end else begin
                setId(1'b1, 5'd8, 5'd11, 1'b1, 1'b1, ADD_CTRL, 32'h401, 32'h0);
                sbq.push_back(k == 1 ? mk(1'b0, 16'h0, 32'h0, 32'h0)
                                     : mk(1'b1, ADD_CTRL, 32'h401, 32'h0));
            end
            #1;
            total++;
            if (obsStall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL flushhaz_stall[%0d] got=%b want=0", k, obsStall);
            end
            tick();
            expRec = sbq.pop_front();
            total++;
            if (obsEx !== expRec || obsCount !== 16'd0) begin
                bad++;
                $display("[TB] FAIL flushhaz_ex[%0d] got=%h cnt=%0d want=%h cnt=0",
                         k, obsEx, obsCount, expRec);
            end
        end
        exFlush = 1'b0;
    endtask

    task automatic test_mid_stall_reset();
        sel = 1'b1;
        doReset(1'b1);
        setId(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, LW_CTRL, 32'h500, 32'h4);
        tick();
        setId(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, ADD_CTRL, 32'h501, 32'h0);
        #1;
        total++;
        if (obsStall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_prestall got=%b want=1", obsStall);
        end
        tick();
        rstB = 1'b0;
        #1;
        total++;
        if (obsStall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_stall_in_reset got=%b want=0", obsStall);
        end
        tick();
        total++;
        if (obsAll !== '0) begin
            bad++;
            $display("[TB] FAIL midrst_outputs got=%h want=0", obsAll);
        end
        rstB = 1'b1;
        sbq.push_back(mk(1'b1, ADD_CTRL, 32'h501, 32'h0));
        #1;
        total++;
        if (obsStall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_run_stall got=%b want=0", obsStall);
        end
        tick();
        expRec = sbq.pop_front();
        total++;
        if (obsEx !== expRec) begin
            bad++;
            $display("[TB] FAIL midrst_ex got=%h want=%h", obsEx, expRec);
        end
    endtask

    task automatic test_saturation();
        sel = 1'b1;
        doReset(1'b1);
        // 21844 full hazards (3 bubbles each) plus 2 flushed ones (1 bubble each)
        for (int h = 0; h < 21846; h++) begin
            setId(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, LW_CTRL, 32'h600, 32'h4);
            tick();
            setId(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, ADD_CTRL, 32'h601, 32'h0);
            tick();
            if (h >= 21844) exFlush = 1'b1;
            tick();
            exFlush = 1'b0;
            if (h < 21844) tick();
        end
        total++;
        if (obsCount !== 16'hFFFE) begin
            bad++;
            $display("[TB] FAIL sat_preload got=%h want=FFFE", obsCount);
        end
        for (int h = 0; h < 2; h++) begin
            setId(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, LW_CTRL, 32'h700, 32'h4);
            tick();
            setId(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, ADD_CTRL, 32'h701, 32'h0);
            tick();
            tick();
            tick();
            total++;
            if (obsCount !== 16'hFFFF) begin
                bad++;
                $display("[TB] FAIL sat_hold[%0d] got=%h want=FFFF", h, obsCount);
            end
        end
    endtask

    initial begin
        sel     = 1'b0;
        rstA    = 1'b0;
        rstB    = 1'b0;
        exFlush = 1'b0;
        setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        test_reset();
        test_passthrough();
        test_load_use(1'b0, 1);
        test_load_use(1'b1, 3);
        test_no_false_hazard();
        test_back_to_back();
        test_flush();
        test_mid_stall_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
